// File: rtl/top_memory_if.sv
// Execute-to-memory and writeback signal bundle for the RV32I memory stage.
// The master drives the E-stage fields; the slave drives the M/W-stage results.
interface top_memory_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] ALUout_E;
    logic [DATA_WIDTH-1:0] WriteData_E;
    logic [DATA_WIDTH-1:0] PCPlus4_E;
    logic [4:0]            Rd_E;
    logic                  RegWrite_E;
    logic                  MemWrite_E;
    logic [1:0]            ResultSrc_E;
    logic [2:0]            funct3_E;

    logic [DATA_WIDTH-1:0] ALUout_M;
    logic [4:0]            Rd_M;
    logic                  RegWrite_M;
    logic [DATA_WIDTH-1:0] Result_W;
    logic [4:0]            Rd_W;
    logic                  RegWrite_W;

    modport master (
        output ALUout_E, WriteData_E, PCPlus4_E, Rd_E, RegWrite_E, MemWrite_E,
               ResultSrc_E, funct3_E,
        input  ALUout_M, Rd_M, RegWrite_M, Result_W, Rd_W, RegWrite_W
    );

    modport slave (
        input  ALUout_E, WriteData_E, PCPlus4_E, Rd_E, RegWrite_E, MemWrite_E,
               ResultSrc_E, funct3_E,
        output ALUout_M, Rd_M, RegWrite_M, Result_W, Rd_W, RegWrite_W
    );
endinterface

// File: rtl/top_memory.sv
// RV32I memory stage: EX/MEM register, little-endian byte-addressed data memory
// with LB/LH/LW/LBU/LHU and SB/SH/SW, writeback mux and MEM/WB register.
module top_memory #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 17
) (
    input logic         clk,
    input logic         rst,
    top_memory_if.slave bus
);
    logic [DATA_WIDTH-1:0] alu_out_d, alu_out_q;
    logic [DATA_WIDTH-1:0] write_data_d, write_data_q;
    logic [DATA_WIDTH-1:0] pc_plus4_d, pc_plus4_q;
    logic [4:0]            rd_m_d, rd_m_q;
    logic                  reg_write_m_d, reg_write_m_q;
    logic                  mem_write_d, mem_write_q;
    logic [1:0]            result_src_d, result_src_q;
    logic [2:0]            funct3_d, funct3_q;
    logic [DATA_WIDTH-1:0] result_d, result_q;
    logic [4:0]            rd_w_d, rd_w_q;
    logic                  reg_write_w_d, reg_write_w_q;

    logic [7:0] mem [0:(1 << ADDR_WIDTH) - 1];

    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            byte_rd;
    logic [15:0]           half_rd;
    logic [31:0]           word_rd;
    logic [DATA_WIDTH-1:0] load_data;

    // Upper address bits are dropped so accesses wrap; half/word are forced aligned.
    assign addr    = alu_out_q[ADDR_WIDTH-1:0];
    assign byte_rd = mem[addr];
    assign half_rd = {mem[{addr[ADDR_WIDTH-1:1], 1'b1}], mem[{addr[ADDR_WIDTH-1:1], 1'b0}]};
    assign word_rd = {mem[{addr[ADDR_WIDTH-1:2], 2'b11}], mem[{addr[ADDR_WIDTH-1:2], 2'b10}],
                      mem[{addr[ADDR_WIDTH-1:2], 2'b01}], mem[{addr[ADDR_WIDTH-1:2], 2'b00}]};

    always_comb begin
        alu_out_d     = bus.ALUout_E;
        write_data_d  = bus.WriteData_E;
        pc_plus4_d    = bus.PCPlus4_E;
        rd_m_d        = bus.Rd_E;
        reg_write_m_d = bus.RegWrite_E;
        mem_write_d   = bus.MemWrite_E;
        result_src_d  = bus.ResultSrc_E;
        funct3_d      = bus.funct3_E;

        load_data = '0;
        case (funct3_q)
            3'b000:  load_data = {{(DATA_WIDTH-8){byte_rd[7]}}, byte_rd};
            3'b001:  load_data = {{(DATA_WIDTH-16){half_rd[15]}}, half_rd};
            3'b010:  load_data = word_rd;
            3'b100:  load_data = {{(DATA_WIDTH-8){1'b0}}, byte_rd};
            3'b101:  load_data = {{(DATA_WIDTH-16){1'b0}}, half_rd};
            default: load_data = '0;
        endcase

        case (result_src_q)
            2'b01:   result_d = load_data;
            2'b10:   result_d = pc_plus4_q;
            default: result_d = alu_out_q;
        endcase
        rd_w_d        = rd_m_q;
        reg_write_w_d = reg_write_m_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_out_q     <= '0;
            write_data_q  <= '0;
            pc_plus4_q    <= '0;
            rd_m_q        <= '0;
            reg_write_m_q <= 1'b0;
            mem_write_q   <= 1'b0;
            result_src_q  <= '0;
            funct3_q      <= '0;
            result_q      <= '0;
            rd_w_q        <= '0;
            reg_write_w_q <= 1'b0;
        end else begin
            alu_out_q     <= alu_out_d;
            write_data_q  <= write_data_d;
            pc_plus4_q    <= pc_plus4_d;
            rd_m_q        <= rd_m_d;
            reg_write_m_q <= reg_write_m_d;
            mem_write_q   <= mem_write_d;
            result_src_q  <= result_src_d;
            funct3_q      <= funct3_d;
            result_q      <= result_d;
            rd_w_q        <= rd_w_d;
            reg_write_w_q <= reg_write_w_d;
        end
    end

    // Memory is not reset; the rst guard keeps a store caught by reset from landing.
    always_ff @(posedge clk) begin
        if (!rst && mem_write_q) begin
            case (funct3_q)
                3'b000: mem[addr] <= write_data_q[7:0];
                3'b001: begin
                    mem[{addr[ADDR_WIDTH-1:1], 1'b0}] <= write_data_q[7:0];
                    mem[{addr[ADDR_WIDTH-1:1], 1'b1}] <= write_data_q[15:8];
                end
                3'b010: begin
                    mem[{addr[ADDR_WIDTH-1:2], 2'b00}] <= write_data_q[7:0];
                    mem[{addr[ADDR_WIDTH-1:2], 2'b01}] <= write_data_q[15:8];
                    mem[{addr[ADDR_WIDTH-1:2], 2'b10}] <= write_data_q[23:16];
                    mem[{addr[ADDR_WIDTH-1:2], 2'b11}] <= write_data_q[31:24];
                end
                default: ;
            endcase
        end
    end

    assign bus.ALUout_M   = alu_out_q;
    assign bus.Rd_M       = rd_m_q;
    assign bus.RegWrite_M = reg_write_m_q;
    assign bus.Result_W   = result_q;
    assign bus.Rd_W       = rd_w_q;
    assign bus.RegWrite_W = reg_write_w_q;
endmodule
